// File: rtl/axi4_lite_master_ctrl_pkg.sv
// Shared definitions for the AXI4-Lite initiator: response codes and FSM state encodings.
package axi4_lite_master_ctrl_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE         = 3'd0,
      ST_WR_ADDR_DATA = 3'd1,
      ST_WR_RESP      = 3'd2,
      ST_RD_ADDR      = 3'd3,
      ST_RD_DATA      = 3'd4,
      ST_RESP         = 3'd5
   } state_e;

endpackage

// File: rtl/axi4_lite_master_ctrl.sv
// Single-outstanding AXI4-Lite initiator: turns one command into an AW/W/B or AR/R exchange
// and holds the captured response until the user takes it.
module axi4_lite_master_ctrl
   import axi4_lite_master_ctrl_pkg::*;
#(
   parameter int          ADDR_WIDTH = 32,
   parameter int          DATA_WIDTH = 32,
   parameter logic [2:0]  PROT       = 3'b000
) (
   input  logic                      iCLK,
   input  logic                      iRST,

   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic                      cmd_write,
   input  logic [ADDR_WIDTH-1:0]     cmd_addr,
   input  logic [DATA_WIDTH-1:0]     cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,

   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic                      rsp_write,
   output logic [1:0]                rsp_resp,
   output logic [DATA_WIDTH-1:0]     rsp_rdata,

   output logic                      m_AWVALID,
   input  logic                      m_AWREADY,
   output logic [2:0]                m_AWPROT,
   output logic [ADDR_WIDTH-1:0]     m_AWADDR,

   output logic                      m_WVALID,
   input  logic                      m_WREADY,
   output logic [DATA_WIDTH-1:0]     m_WDATA,
   output logic [DATA_WIDTH/8-1:0]   m_WSTRB,

   input  logic                      m_BVALID,
   output logic                      m_BREADY,
   input  logic [1:0]                m_BRESP,

   output logic                      m_ARVALID,
   input  logic                      m_ARREADY,
   output logic [2:0]                m_ARPROT,
   output logic [ADDR_WIDTH-1:0]     m_ARADDR,

   input  logic                      m_RVALID,
   output logic                      m_RREADY,
   input  logic [1:0]                m_RRESP,
   input  logic [DATA_WIDTH-1:0]     m_RDATA
);

   state_e                    state_q, state_d;
   logic                      awvalid_q, awvalid_d;
   logic                      wvalid_q, wvalid_d;
   logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
   logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
   logic [DATA_WIDTH/8-1:0]   wstrb_q, wstrb_d;
   logic                      rsp_write_q, rsp_write_d;
   logic [1:0]                rsp_resp_q, rsp_resp_d;
   logic [DATA_WIDTH-1:0]     rsp_rdata_q, rsp_rdata_d;

   // Next-state and datapath update; a cleared per-channel VALID doubles as that channel's done flag.
   always_comb begin
      state_d     = state_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      rsp_write_d = rsp_write_q;
      rsp_resp_d  = rsp_resp_q;
      rsp_rdata_d = rsp_rdata_q;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               addr_d  = cmd_addr;
               wdata_d = cmd_wdata;
               wstrb_d = cmd_wstrb;
               if (cmd_write) begin
                  state_d   = ST_WR_ADDR_DATA;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
               end else begin
                  state_d = ST_RD_ADDR;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_WR_ADDR_DATA: begin
            if (awvalid_q && m_AWREADY) begin
               awvalid_d = 1'b0;
            end else begin
               awvalid_d = awvalid_q;
            end
            if (wvalid_q && m_WREADY) begin
               wvalid_d = 1'b0;
            end else begin
               wvalid_d = wvalid_q;
            end
            if ((!awvalid_q || m_AWREADY) && (!wvalid_q || m_WREADY)) begin
               state_d = ST_WR_RESP;
            end else begin
               state_d = ST_WR_ADDR_DATA;
            end
         end

         ST_WR_RESP: begin
            if (m_BVALID) begin
               rsp_resp_d  = m_BRESP;
               rsp_rdata_d = {DATA_WIDTH{1'b0}};
               rsp_write_d = 1'b1;
               state_d     = ST_RESP;
            end else begin
               state_d = ST_WR_RESP;
            end
         end

         ST_RD_ADDR: begin
            if (m_ARREADY) begin
               state_d = ST_RD_DATA;
            end else begin
               state_d = ST_RD_ADDR;
            end
         end

         ST_RD_DATA: begin
            if (m_RVALID) begin
               rsp_resp_d  = m_RRESP;
               rsp_rdata_d = m_RDATA;
               rsp_write_d = 1'b0;
               state_d     = ST_RESP;
            end else begin
               state_d = ST_RD_DATA;
            end
         end

         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RESP;
            end
         end

         default: begin
            state_d   = ST_IDLE;
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
         end
      endcase
   end

   // State and datapath registers; reset abandons any transaction in flight.
   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         state_q     <= ST_IDLE;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         addr_q      <= {ADDR_WIDTH{1'b0}};
         wdata_q     <= {DATA_WIDTH{1'b0}};
         wstrb_q     <= {(DATA_WIDTH/8){1'b0}};
         rsp_write_q <= 1'b0;
         rsp_resp_q  <= RESP_OKAY;
         rsp_rdata_q <= {DATA_WIDTH{1'b0}};
      end else begin
         state_q     <= state_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         rsp_write_q <= rsp_write_d;
         rsp_resp_q  <= rsp_resp_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign cmd_ready = (state_q == ST_IDLE);
   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_write = rsp_write_q;
   assign rsp_resp  = rsp_resp_q;
   assign rsp_rdata = rsp_rdata_q;

   assign m_AWVALID = awvalid_q;
   assign m_AWPROT  = PROT;
   assign m_AWADDR  = addr_q;
   assign m_WVALID  = wvalid_q;
   assign m_WDATA   = wdata_q;
   assign m_WSTRB   = wstrb_q;
   assign m_BREADY  = (state_q == ST_WR_RESP);
   assign m_ARVALID = (state_q == ST_RD_ADDR);
   assign m_ARPROT  = PROT;
   assign m_ARADDR  = addr_q;
   assign m_RREADY  = (state_q == ST_RD_DATA);

endmodule

// File: tb/tb_axi4_lite_master_ctrl.sv
// Directed bench for axi4_lite_master_ctrl: inputs change and outputs are sampled on the falling edge.
module tb_axi4_lite_master_ctrl;
   import axi4_lite_master_ctrl_pkg::*;

   logic          iCLK, iRST;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [31:0]   cmd_addr, cmd_wdata;
   logic [3:0]    cmd_wstrb;
   logic          rsp_valid, rsp_ready, rsp_write;
   logic [1:0]    rsp_resp;
   logic [31:0]   rsp_rdata;
   logic          m_AWVALID, m_AWREADY;
   logic [2:0]    m_AWPROT;
   logic [31:0]   m_AWADDR;
   logic          m_WVALID, m_WREADY;
   logic [31:0]   m_WDATA;
   logic [3:0]    m_WSTRB;
   logic          m_BVALID, m_BREADY;
   logic [1:0]    m_BRESP;
   logic          m_ARVALID, m_ARREADY;
   logic [2:0]    m_ARPROT;
   logic [31:0]   m_ARADDR;
   logic          m_RVALID, m_RREADY;
   logic [1:0]    m_RRESP;
   logic [31:0]   m_RDATA;

   int total = 0;
   int bad   = 0;
   int b_hs  = 0;
   int b_hs_start;

   axi4_lite_master_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .PROT(3'b000)) dut (
      .iCLK(iCLK), .iRST(iRST),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
      .rsp_resp(rsp_resp), .rsp_rdata(rsp_rdata),
      .m_AWVALID(m_AWVALID), .m_AWREADY(m_AWREADY), .m_AWPROT(m_AWPROT), .m_AWADDR(m_AWADDR),
      .m_WVALID(m_WVALID), .m_WREADY(m_WREADY), .m_WDATA(m_WDATA), .m_WSTRB(m_WSTRB),
      .m_BVALID(m_BVALID), .m_BREADY(m_BREADY), .m_BRESP(m_BRESP),
      .m_ARVALID(m_ARVALID), .m_ARREADY(m_ARREADY), .m_ARPROT(m_ARPROT), .m_ARADDR(m_ARADDR),
      .m_RVALID(m_RVALID), .m_RREADY(m_RREADY), .m_RRESP(m_RRESP), .m_RDATA(m_RDATA)
   );

   initial iCLK = 1'b0;
   always #5 iCLK = ~iCLK;

   // Counts B-channel handshakes so a doubly captured response is visible.
   always @(posedge iCLK) begin
      if (m_BVALID === 1'b1 && m_BREADY === 1'b1) b_hs <= b_hs + 1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(negedge iCLK);
   endtask

   task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
   endtask

   initial begin
      iRST = 1'b0;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0; cmd_wstrb = 4'h0;
      rsp_ready = 1'b0;
      m_AWREADY = 1'b0; m_WREADY = 1'b0; m_BVALID = 1'b0; m_BRESP = 2'b00;
      m_ARREADY = 1'b0; m_RVALID = 1'b0; m_RRESP = 2'b00; m_RDATA = 32'h0;
      #1;
      chk("rst_awvalid", m_AWVALID, 1'b0);
      chk("rst_wvalid", m_WVALID, 1'b0);
      chk("rst_arvalid", m_ARVALID, 1'b0);
      chk("rst_bready", m_BREADY, 1'b0);
      chk("rst_rready", m_RREADY, 1'b0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rsp_fields", {rsp_write, rsp_resp, rsp_rdata}, 35'h0);
      chk("rst_regs", {m_AWADDR, m_WDATA, m_WSTRB}, 68'h0);
      nxt(); nxt();
      iRST = 1'b1;
      nxt();
      chk("idle_cmd_ready", cmd_ready, 1'b1);

      // Write, always-ready slave, BRESP OKAY
      issue(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
      m_AWREADY = 1'b1; m_WREADY = 1'b1; m_BVALID = 1'b1; m_BRESP = RESP_OKAY;
      nxt(); cmd_valid = 1'b0;                                  // cycle T+1
      chk("w1_aw_w_valid", {m_AWVALID, m_WVALID}, 2'b11);
      chk("w1_awaddr", m_AWADDR, 32'h0000_0010);
      chk("w1_wdata", m_WDATA, 32'hDEAD_BEEF);
      chk("w1_wstrb", m_WSTRB, 4'hF);
      chk("w1_prot", m_AWPROT, 3'b000);
      chk("w1_bready_t1", m_BREADY, 1'b0);
      chk("w1_cmd_ready_busy", cmd_ready, 1'b0);
      nxt();                                                    // T+2
      chk("w1_valid_drop", {m_AWVALID, m_WVALID}, 2'b00);
      chk("w1_bready_t2", m_BREADY, 1'b1);
      chk("w1_rsp_valid_t2", rsp_valid, 1'b0);
      nxt(); m_BVALID = 1'b0; rsp_ready = 1'b1;                 // T+3
      chk("w1_rsp_valid_t3", rsp_valid, 1'b1);
      chk("w1_rsp", {rsp_write, rsp_resp, rsp_rdata}, {1'b1, RESP_OKAY, 32'h0});
      chk("w1_bready_t3", m_BREADY, 1'b0);
      nxt(); rsp_ready = 1'b0;
      chk("w1_back_idle", {rsp_valid, cmd_ready}, 2'b01);

      // Read, ARREADY after 3 wait cycles, RRESP OKAY
      m_AWREADY = 1'b0; m_WREADY = 1'b0;
      issue(1'b0, 32'h0000_0020, 32'h0, 4'h0);
      for (int i = 0; i < 4; i++) begin
         nxt(); cmd_valid = 1'b0;
         chk("r1_arvalid_held", m_ARVALID, 1'b1);
         chk("r1_araddr", m_ARADDR, 32'h0000_0020);
         chk("r1_rready_early", m_RREADY, 1'b0);
         if (i == 3) m_ARREADY = 1'b1;
      end
      nxt(); m_ARREADY = 1'b0;
      m_RVALID = 1'b1; m_RDATA = 32'h1234_5678; m_RRESP = RESP_OKAY;
      chk("r1_ar_after_hs", {m_ARVALID, m_RREADY}, 2'b01);
      nxt(); m_RVALID = 1'b0; rsp_ready = 1'b1;
      chk("r1_rsp_valid", rsp_valid, 1'b1);
      chk("r1_rsp", {rsp_write, rsp_resp, rsp_rdata}, {1'b0, RESP_OKAY, 32'h1234_5678});
      nxt(); rsp_ready = 1'b0;
      chk("r1_back_idle", cmd_ready, 1'b1);

      // Write, AWREADY delayed 4 cycles, WREADY immediate
      m_AWREADY = 1'b0; m_WREADY = 1'b1; m_BVALID = 1'b0;
      issue(1'b1, 32'h0000_0040, 32'h0BAD_F00D, 4'h5);
      nxt(); cmd_valid = 1'b0;                                  // T+1
      chk("w2_t1_valids", {m_AWVALID, m_WVALID, m_BREADY}, 3'b110);
      for (int k = 2; k <= 5; k++) begin
         nxt();
         chk("w2_aw_held_w_done", {m_AWVALID, m_WVALID, m_BREADY}, 3'b100);
         chk("w2_awaddr_stable", m_AWADDR, 32'h0000_0040);
         if (k == 5) m_AWREADY = 1'b1;
      end
      nxt(); m_AWREADY = 1'b0; m_BVALID = 1'b1; m_BRESP = RESP_EXOKAY;   // T+6
      chk("w2_bready_after_both", {m_AWVALID, m_WVALID, m_BREADY}, 3'b001);
      nxt(); m_BVALID = 1'b0; rsp_ready = 1'b1;                          // T+7
      chk("w2_rsp", {rsp_valid, rsp_write, rsp_resp, rsp_rdata}, {1'b1, 1'b1, RESP_EXOKAY, 32'h0});
      nxt(); rsp_ready = 1'b0;
      chk("w2_back_idle", cmd_ready, 1'b1);

      // Read SLVERR, response held 5 cycles before rsp_ready
      m_WREADY = 1'b0; m_ARREADY = 1'b1;
      m_RVALID = 1'b1; m_RDATA = 32'hCAFE_F00D; m_RRESP = RESP_SLVERR;
      issue(1'b0, 32'h0000_0030, 32'h0, 4'h0);
      nxt(); cmd_valid = 1'b0;
      chk("r2_arvalid", m_ARVALID, 1'b1);
      nxt();
      chk("r2_rready", m_RREADY, 1'b1);
      for (int k = 0; k < 5; k++) begin
         nxt(); m_RVALID = 1'b0; m_ARREADY = 1'b0;
         chk("r2_rsp_held", {rsp_valid, rsp_write, rsp_resp, rsp_rdata},
             {1'b1, 1'b0, RESP_SLVERR, 32'hCAFE_F00D});
         chk("r2_cmd_ready_low", cmd_ready, 1'b0);
         if (k == 4) rsp_ready = 1'b1;
      end
      nxt(); rsp_ready = 1'b0;
      chk("r2_cmd_ready_after", {rsp_valid, cmd_ready}, 2'b01);

      // Early BVALID (DECERR) before W handshake
      b_hs_start = b_hs;
      m_BVALID = 1'b1; m_BRESP = RESP_DECERR; m_AWREADY = 1'b1; m_WREADY = 1'b0;
      issue(1'b1, 32'h0000_0050, 32'h1111_2222, 4'h3);
      nxt(); cmd_valid = 1'b0;                                  // T+1
      chk("w3_t1", {m_AWVALID, m_WVALID, m_BREADY}, 3'b110);
      nxt(); m_WREADY = 1'b1;                                   // T+2
      chk("w3_t2", {m_AWVALID, m_WVALID, m_BREADY}, 3'b010);
      chk("w3_wdata_stable", m_WDATA, 32'h1111_2222);
      nxt(); m_WREADY = 1'b0; m_AWREADY = 1'b0;                 // T+3
      chk("w3_t3_bready", {m_WVALID, m_BREADY}, 2'b01);
      chk("w3_no_early_b", b_hs - b_hs_start, 0);
      nxt();                                                    // T+4
      chk("w3_rsp", {rsp_valid, rsp_write, rsp_resp}, {1'b1, 1'b1, RESP_DECERR});
      nxt(); rsp_ready = 1'b1;                                  // T+5, BVALID still high
      chk("w3_rsp_hold", {rsp_valid, m_BREADY, rsp_resp}, {1'b1, 1'b0, RESP_DECERR});
      nxt(); rsp_ready = 1'b0; m_BVALID = 1'b0;
      chk("w3_b_once", b_hs - b_hs_start, 1);
      chk("w3_back_idle", cmd_ready, 1'b1);

      // Reset pulse during WR_ADDR_DATA, then a normal read
      issue(1'b1, 32'h0000_0060, 32'h7777_8888, 4'hF);
      nxt(); cmd_valid = 1'b0;
      chk("x_in_wr", {m_AWVALID, m_WVALID}, 2'b11);
      iRST = 1'b0;
      #1;
      chk("x_rst_valids", {m_AWVALID, m_WVALID, m_ARVALID, m_BREADY, m_RREADY, rsp_valid}, 6'b0);
      chk("x_rst_regs", {m_AWADDR, m_WDATA, m_WSTRB}, 68'h0);
      nxt(); iRST = 1'b1;
      nxt();
      chk("x_after_rst", {cmd_ready, rsp_valid, m_AWVALID}, 3'b100);
      m_ARREADY = 1'b1; m_RVALID = 1'b1; m_RDATA = 32'hA5A5_0001; m_RRESP = RESP_OKAY;
      issue(1'b0, 32'h0000_0070, 32'h0, 4'h0);
      nxt(); cmd_valid = 1'b0;
      chk("x_rd_ar", {m_ARVALID, m_ARADDR}, {1'b1, 32'h0000_0070});
      nxt();
      chk("x_rd_rready", m_RREADY, 1'b1);
      nxt(); m_RVALID = 1'b0; m_ARREADY = 1'b0; rsp_ready = 1'b1;
      chk("x_rd_rsp", {rsp_valid, rsp_write, rsp_resp, rsp_rdata}, {1'b1, 1'b0, RESP_OKAY, 32'hA5A5_0001});
      nxt(); rsp_ready = 1'b0;
      chk("x_rd_idle", cmd_ready, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
